// File: rtl/ysyx_24070016_regfile_sb_if.sv
// Bundle of read-port, writeback, issue and flush signals shared by the
// scoreboarded register file and its client (issue/writeback stages).
interface ysyx_24070016_regfile_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_RD      = 2
);
    logic [NR_RD*ADDR_WIDTH-1:0] raddr;
    logic [NR_RD*DATA_WIDTH-1:0] rdata;
    logic [NR_RD-1:0]            rbusy;
    logic                        wen;
    logic [ADDR_WIDTH-1:0]       waddr;
    logic [DATA_WIDTH-1:0]       wdata;
    logic                        iss_valid;
    logic [ADDR_WIDTH-1:0]       iss_rd;
    logic                        flush;
    logic                        busy_any;

    modport master (
        output raddr, wen, waddr, wdata, iss_valid, iss_rd, flush,
        input  rdata, rbusy, busy_any
    );

    modport slave (
        input  raddr, wen, waddr, wdata, iss_valid, iss_rd, flush,
        output rdata, rbusy, busy_any
    );
endinterface

// File: rtl/ysyx_24070016_regfile_sb.sv
// Multi-read-port integer register file with write-to-read bypass and a
// per-register busy scoreboard; x0 has no storage and is never busy.
module ysyx_24070016_regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_RD      = 2
) (
    input logic                          clk,
    input logic                          rst_n,
    ysyx_24070016_regfile_sb_if.slave    bus
);
    localparam int NR_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf_reg [1:NR_REGS-1];
    logic [NR_REGS-1:1]    busy_reg;
    logic [NR_REGS-1:1]    busy_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NR_REGS; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NR_REGS; i++) begin
                if (bus.wen && (bus.waddr == ADDR_WIDTH'(i))) begin
                    rf_reg[i] <= bus.wdata;
                end
            end
        end
    end

    // Flush beats a new issue, and a new issue beats the writeback clear, so a
    // register re-issued in its writeback cycle stays pending for the new producer.
    always_comb begin
        busy_next = busy_reg;
        for (int i = 1; i < NR_REGS; i++) begin
            if (bus.flush) begin
                busy_next[i] = 1'b0;
            end else if (bus.iss_valid && (bus.iss_rd == ADDR_WIDTH'(i))) begin
                busy_next[i] = 1'b1;
            end else if (bus.wen && (bus.waddr == ADDR_WIDTH'(i))) begin
                busy_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Reset forces all read outputs low even if a writeback is being driven.
    always_comb begin
        logic [ADDR_WIDTH-1:0] a;
        a         = '0;
        bus.rdata = '0;
        bus.rbusy = '0;
        for (int p = 0; p < NR_RD; p++) begin
            a = bus.raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (!rst_n || (a == '0)) begin
                bus.rdata[p*DATA_WIDTH +: DATA_WIDTH] = '0;
                bus.rbusy[p]                          = 1'b0;
            end else if (bus.wen && (bus.waddr == a)) begin
                bus.rdata[p*DATA_WIDTH +: DATA_WIDTH] = bus.wdata;
                bus.rbusy[p]                          = 1'b0;
            end else begin
                bus.rdata[p*DATA_WIDTH +: DATA_WIDTH] = rf_reg[a];
                bus.rbusy[p]                          = busy_reg[a];
            end
        end
    end

    assign bus.busy_any = |busy_reg;

endmodule

// File: tb/tb_ysyx_24070016_regfile_sb.sv
// Scoreboard bench for the register file: expectations are queued as stimulus
// is driven and drained at the falling edge, one printed line per comparison.
module tb_ysyx_24070016_regfile_sb;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;

    logic clk;
    logic rst_n;

    ysyx_24070016_regfile_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_RD(NR)) bus ();

    ysyx_24070016_regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_RD(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;   // 0 rdata, 1 rbusy, 2 busy_any
        int          port;
        logic [31:0] value;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] obs;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_rf   [32];
    logic        m_busy [32];

    task automatic push(input string n, input int k, input int p, input logic [31:0] v);
        exp_t x;
        x.name = n; x.kind = k; x.port = p; x.value = v;
        sb.push_back(x);
    endtask

    function automatic logic [31:0] observe(input int k, input int p);
        if (k == 0) return bus.rdata[p*DW +: DW];
        if (k == 1) return {31'b0, bus.rbusy[p]};
        return {31'b0, bus.busy_any};
    endfunction

    task automatic set_raddr(input int p, input logic [AW-1:0] a);
        bus.raddr[p*AW +: AW] = a;
    endtask

    task automatic idle();
        bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.flush = 1'b0;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            rst_n = 1'b0;
            idle();
            for (int p = 0; p < NR; p++) set_raddr(p, AW'($urandom_range(1, 31)));
            for (int p = 0; p < NR; p++) begin
                push("reset_rdata", 0, p, 32'h0);
                push("reset_rbusy", 1, p, 32'h0);
            end
            push("reset_busy_any", 2, 0, 32'h0);
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.kind, e.port); checks++;
                if (obs !== e.value) begin
                    errors++;
                    $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, obs, e.value);
                end else $display("ok   %s port%0d = %h", e.name, e.port, obs);
            end
            next_edge();
        end
        #3 rst_n = 1'b1;
        next_edge();
    endtask

    task automatic test_async_reset();
        for (int s = 0; s < 3; s++) begin
            idle();
            case (s)
                0: begin
                    bus.wen = 1'b1; bus.waddr = 5; bus.wdata = 32'hDEADBEEF;
                    bus.iss_valid = 1'b1; bus.iss_rd = 6;
                    set_raddr(0, 5);
                    push("wr5_bypass", 0, 0, 32'hDEADBEEF);
                end
                1: begin
                    set_raddr(0, 5); set_raddr(1, 6);
                    push("wr5_stored", 0, 0, 32'hDEADBEEF);
                    push("x6_busy", 1, 1, 32'h1);
                end
                default: begin
                    rst_n = 1'b0;
                    #1;
                    push("async_rst_x5", 0, 0, 32'h0);
                    push("async_rst_x6busy", 1, 1, 32'h0);
                    push("async_rst_busy_any", 2, 0, 32'h0);
                end
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.kind, e.port); checks++;
                if (obs !== e.value) begin
                    errors++;
                    $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, obs, e.value);
                end else $display("ok   %s port%0d = %h", e.name, e.port, obs);
            end
            if (s == 2) #2 rst_n = 1'b1;
            next_edge();
        end
    endtask

    task automatic test_write_bypass();
        for (int s = 0; s < 4; s++) begin
            idle();
            case (s)
                0: begin
                    bus.wen = 1'b1; bus.waddr = 3; bus.wdata = 32'h12345678;
                    set_raddr(0, 3);
                    push("bypass_x3", 0, 0, 32'h12345678);
                    push("bypass_x3_busy", 1, 0, 32'h0);
                end
                1: begin
                    set_raddr(0, 3);
                    push("stored_x3", 0, 0, 32'h12345678);
                end
                2: begin
                    bus.wen = 1'b1; bus.waddr = 0; bus.wdata = 32'hFFFFFFFF;
                    set_raddr(0, 0);
                    push("x0_write_bypass", 0, 0, 32'h0);
                    push("x0_busy", 1, 0, 32'h0);
                end
                default: begin
                    set_raddr(0, 0);
                    push("x0_after_write", 0, 0, 32'h0);
                end
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.kind, e.port); checks++;
                if (obs !== e.value) begin
                    errors++;
                    $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, obs, e.value);
                end else $display("ok   %s port%0d = %h", e.name, e.port, obs);
            end
            next_edge();
        end
    endtask

    task automatic test_scoreboard();
        for (int s = 0; s < 4; s++) begin
            idle();
            set_raddr(0, 7);
            case (s)
                0: begin
                    bus.iss_valid = 1'b1; bus.iss_rd = 7;
                    push("iss7_same_cycle_busy", 1, 0, 32'h0);
                    push("iss7_same_cycle_any", 2, 0, 32'h0);
                end
                1: begin
                    push("x7_busy", 1, 0, 32'h1);
                    push("x7_busy_any", 2, 0, 32'h1);
                end
                2: begin
                    bus.wen = 1'b1; bus.waddr = 7; bus.wdata = 32'hA5;
                    push("wb7_bypass", 0, 0, 32'hA5);
                    push("wb7_rbusy", 1, 0, 32'h0);
                    push("wb7_busy_any_reg", 2, 0, 32'h1);
                end
                default: begin
                    push("x7_after_wb", 0, 0, 32'hA5);
                    push("x7_cleared", 1, 0, 32'h0);
                    push("busy_any_cleared", 2, 0, 32'h0);
                end
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.kind, e.port); checks++;
                if (obs !== e.value) begin
                    errors++;
                    $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, obs, e.value);
                end else $display("ok   %s port%0d = %h", e.name, e.port, obs);
            end
            next_edge();
        end
    endtask

    task automatic test_collision();
        for (int s = 0; s < 7; s++) begin
            idle();
            set_raddr(0, 9); set_raddr(1, 0);
            case (s)
                0: begin bus.iss_valid = 1'b1; bus.iss_rd = 9; end
                1: push("x9_busy", 1, 0, 32'h1);
                2: begin
                    bus.iss_valid = 1'b1; bus.iss_rd = 9;
                    bus.wen = 1'b1; bus.waddr = 9; bus.wdata = 32'h55;
                    push("coll_bypass", 0, 0, 32'h55);
                    push("coll_bypass_busy", 1, 0, 32'h0);
                end
                3: begin
                    bus.iss_valid = 1'b1; bus.iss_rd = 0;
                    push("coll_stored", 0, 0, 32'h55);
                    push("coll_still_busy", 1, 0, 32'h1);
                end
                4: begin
                    push("x0_never_busy", 1, 1, 32'h0);
                    push("x0_reads_zero", 0, 1, 32'h0);
                    push("busy_any_x9", 2, 0, 32'h1);
                end
                5: begin bus.wen = 1'b1; bus.waddr = 9; bus.wdata = 32'h56; end
                default: begin
                    push("x9_final", 0, 0, 32'h56);
                    push("x9_final_busy", 1, 0, 32'h0);
                    push("busy_any_idle", 2, 0, 32'h0);
                end
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.kind, e.port); checks++;
                if (obs !== e.value) begin
                    errors++;
                    $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, obs, e.value);
                end else $display("ok   %s port%0d = %h", e.name, e.port, obs);
            end
            next_edge();
        end
    endtask

    task automatic test_flush();
        for (int s = 0; s < 6; s++) begin
            idle();
            set_raddr(0, 1); set_raddr(1, 2); set_raddr(2, 3); set_raddr(3, 4);
            case (s)
                0, 1, 2: begin bus.iss_valid = 1'b1; bus.iss_rd = AW'(s + 1); end
                3: begin
                    for (int p = 0; p < 3; p++) push("pre_flush_busy", 1, p, 32'h1);
                    push("pre_flush_x4", 1, 3, 32'h0);
                    push("pre_flush_any", 2, 0, 32'h1);
                end
                4: begin
                    bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 4;
                    bus.wen = 1'b1; bus.waddr = 2; bus.wdata = 32'h77;
                    push("flush_bypass_x2", 0, 1, 32'h77);
                    push("flush_cycle_any", 2, 0, 32'h1);
                end
                default: begin
                    for (int p = 0; p < NR; p++) push("post_flush_busy", 1, p, 32'h0);
                    push("post_flush_any", 2, 0, 32'h0);
                    push("post_flush_x2", 0, 1, 32'h77);
                end
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.kind, e.port); checks++;
                if (obs !== e.value) begin
                    errors++;
                    $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, obs, e.value);
                end else $display("ok   %s port%0d = %h", e.name, e.port, obs);
            end
            next_edge();
        end
    endtask

    task automatic test_multiport();
        for (int s = 0; s < 6; s++) begin
            idle();
            case (s)
                0: begin bus.wen = 1'b1; bus.waddr = 10; bus.wdata = 32'h1010; end
                1: begin bus.wen = 1'b1; bus.waddr = 11; bus.wdata = 32'h1111; end
                2: begin bus.iss_valid = 1'b1; bus.iss_rd = 11; end
                3: begin
                    bus.wen = 1'b1; bus.waddr = 12; bus.wdata = 32'hC0C0;
                    set_raddr(0, 0); set_raddr(1, 11); set_raddr(2, 12); set_raddr(3, 10);
                    push("mp_x0", 0, 0, 32'h0);     push("mp_x0_busy", 1, 0, 32'h0);
                    push("mp_x11", 0, 1, 32'h1111); push("mp_x11_busy", 1, 1, 32'h1);
                    push("mp_x12_byp", 0, 2, 32'hC0C0); push("mp_x12_busy", 1, 2, 32'h0);
                    push("mp_x10", 0, 3, 32'h1010); push("mp_x10_busy", 1, 3, 32'h0);
                end
                4: begin
                    bus.wen = 1'b1; bus.waddr = 11; bus.wdata = 32'h2222;
                    set_raddr(0, 11); set_raddr(1, 11); set_raddr(2, 12); set_raddr(3, 0);
                    push("mp_x11_byp_a", 0, 0, 32'h2222); push("mp_x11_byp_a_busy", 1, 0, 32'h0);
                    push("mp_x11_byp_b", 0, 1, 32'h2222); push("mp_x11_byp_b_busy", 1, 1, 32'h0);
                    push("mp_x12", 0, 2, 32'hC0C0);
                    push("mp_x0b", 0, 3, 32'h0);
                end
                default: begin
                    set_raddr(0, 11); set_raddr(1, 0); set_raddr(2, 11); set_raddr(3, 10);
                    push("mp_x11_st_a", 0, 0, 32'h2222); push("mp_x11_st_busy", 1, 0, 32'h0);
                    push("mp_x0c", 0, 1, 32'h0);
                    push("mp_x11_st_b", 0, 2, 32'h2222);
                    push("mp_x10b", 0, 3, 32'h1010);
                end
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.kind, e.port); checks++;
                if (obs !== e.value) begin
                    errors++;
                    $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, obs, e.value);
                end else $display("ok   %s port%0d = %h", e.name, e.port, obs);
            end
            next_edge();
        end
    endtask

    task automatic test_random();
        logic        any;
        logic [4:0]  a;
        #2 rst_n = 1'b0;
        for (int r = 0; r < 32; r++) begin m_rf[r] = '0; m_busy[r] = 1'b0; end
        #2 rst_n = 1'b1;
        next_edge();
        for (int s = 0; s < 60; s++) begin
            idle();
            bus.wen       = ($urandom_range(0, 1) == 1);
            bus.waddr     = AW'($urandom_range(0, 7));
            bus.wdata     = $urandom;
            bus.iss_valid = ($urandom_range(0, 2) != 0);
            bus.iss_rd    = AW'($urandom_range(0, 7));
            bus.flush     = ($urandom_range(0, 9) == 0);
            for (int p = 0; p < NR; p++) set_raddr(p, AW'($urandom_range(0, 7)));
            any = 1'b0;
            for (int r = 1; r < 32; r++) any = any | m_busy[r];
            for (int p = 0; p < NR; p++) begin
                a = bus.raddr[p*AW +: AW];
                if (a == 0) begin
                    push("rnd_rdata", 0, p, 32'h0); push("rnd_rbusy", 1, p, 32'h0);
                end else if (bus.wen && bus.waddr == a) begin
                    push("rnd_rdata", 0, p, bus.wdata); push("rnd_rbusy", 1, p, 32'h0);
                end else begin
                    push("rnd_rdata", 0, p, m_rf[a]); push("rnd_rbusy", 1, p, {31'b0, m_busy[a]});
                end
            end
            push("rnd_busy_any", 2, 0, {31'b0, any});
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.kind, e.port); checks++;
                if (obs !== e.value) begin
                    errors++;
                    $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, obs, e.value);
                end else $display("ok   %s port%0d = %h", e.name, e.port, obs);
            end
            if (bus.wen && bus.waddr != 0) m_rf[bus.waddr] = bus.wdata;
            if (bus.flush) begin
                for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            end else begin
                if (bus.wen && bus.waddr != 0) m_busy[bus.waddr] = 1'b0;
                if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
            end
            next_edge();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.raddr = '0;
        idle();
        #1;
        test_reset();
        test_async_reset();
        test_write_bypass();
        test_scoreboard();
        test_collision();
        test_flush();
        test_multiport();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24070016_regfile_sb.md
# ysyx_24070016_regfile_sb

Parametrised multi-read-port integer register file with asynchronous zero-reset, same-cycle write-to-read bypass and a per-register busy scoreboard. It sits between decode/issue and writeback in the NPC core. Issue marks a destination register pending, writeback clears it, and read ports report whether each source operand is still pending so the issue stage can stall.

## Interface
- `ADDR_WIDTH`, default 5: register index width; the file holds 2**ADDR_WIDTH entries.
- `DATA_WIDTH`, default 32: register width.
- `NR_RD`, default 2: number of read ports, minimum 1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `raddr` input NR_RD*ADDR_WIDTH: read addresses; port i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `rdata` output NR_RD*DATA_WIDTH: read data; port i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `rbusy` output NR_RD: port i's source register is pending a writeback.
- `wen` input 1: writeback enable.
- `waddr` input ADDR_WIDTH: writeback register index.
- `wdata` input DATA_WIDTH: writeback data.
- `iss_valid` input 1: an instruction with a destination register issues this cycle.
- `iss_rd` input ADDR_WIDTH: destination register index of the issuing instruction.
- `flush` input 1: clear all busy bits (pipeline squash).
- `busy_any` output 1: OR of all busy bits.

## Operation
- Storage:
  - rf[1..N-1] of DATA_WIDTH bits, plus busy[1..N-1].
  - Index 0 has no storage. It always reads 0, is never busy, and writes and issues to it are ignored.
- Reset (rst_n low, asynchronous):
  - Every rf entry is 0 and every busy bit is 0.
  - Outputs follow combinationally: rdata reflects 0 at every port, rbusy = 0, busy_any = 0.
  - Reset asserted mid-operation discards all pending writes and scoreboard state immediately.
- Write: on a clock edge with wen=1 and waddr≠0, rf[waddr] ← wdata.
  - A write to a non-busy register is legal and performed.
- Read (combinational, per port i, with a = raddr[i]):
  - a = 0: rdata[i] = 0, rbusy[i] = 0.
  - wen=1 and waddr = a: rdata[i] = wdata (bypass), rbusy[i] = 0.
  - Otherwise: rdata[i] = rf[a], rbusy[i] = busy[a].
  - Iss_valid does not affect read outputs in the same cycle.
- Busy update at a clock edge, highest priority first:
  - flush=1: all busy bits ← 0. Iss_valid is ignored that cycle; the wen data write still occurs.
  - iss_valid=1 and iss_rd≠0: busy[iss_rd] ← 1. This holds even if wen=1 with waddr = iss_rd in the same cycle; the write data is stored and the register stays busy for the new producer.
  - wen=1 and waddr≠0: busy[waddr] ← 0, where not overridden by the two rules above.
  - An issue to register r and a writeback to a different register s in the same cycle both take effect.
- busy_any is the OR of the registered busy bits and excludes same-cycle bypass.
- One outstanding producer per register. Issuing to an already-busy register keeps it busy; the first matching writeback clears it. Ordering is the issue stage's responsibility.

## Timing
- Read path: zero latency, combinational from raddr, wen, waddr, wdata and the state.
- Write and scoreboard: visible in rf/busy one cycle after the capturing edge. Same-cycle visibility of a write comes only through the bypass.
- No handshakes. All inputs are sampled at every rising edge while rst_n is high.
- The first edge after rst_n deasserts is a normal update edge.

## Test plan
- Reset value: hold rst_n=0, drive raddr with arbitrary values -> rdata=0 on every port, rbusy=0, busy_any=0. Assert rst_n low asynchronously between edges after writing x5=0xDEADBEEF -> rdata at x5 reads 0 immediately.
- Write, read and bypass: wen=1, waddr=3, wdata=0x12345678 with raddr port0=3 -> rdata0=0x12345678 in the same cycle. Next cycle with wen=0 -> still 0x12345678. Write to x0 with 0xFFFFFFFF -> reading x0 returns 0.
- Scoreboard: iss_valid, iss_rd=7 -> next cycle rbusy=1 for x7 and busy_any=1. Then wen, waddr=7, wdata=0xA5 -> rbusy=0 that same cycle with rdata=0xA5; next cycle busy_any=0.
- Issue/write collision: x9 busy, then one cycle with iss_valid, iss_rd=9, wen, waddr=9, wdata=0x55 -> next cycle rf[9]=0x55 and rbusy for x9 is 1. Iss_rd=0 -> x0 never busy.
- Flush priority: busy on x1, x2, x3, then flush=1 with iss_valid, iss_rd=4 and wen, waddr=2, wdata=0x77 -> next cycle all rbusy=0, busy_any=0, rf[2]=0x77.
- Multi-port: NR_RD=4, all four ports read distinct and identical addresses including 0 and the bypass target -> each port independently matches the read rules above.
